tcam_search_reader: RTL and testbench
=====================================

// Module: tcam_search_reader
// PURPOSE
//   Read-side controller for ternary_content_addressable_memory. Accepts a search key and
//   mask, drives them onto the TCAM search lines with write held low, and captures the
//   resulting match vector. It then streams every matching address, lowest first, over a
//   valid/ready interface. Sits between search clients and the TCAM instance.
// PARAMETERS
//   word_size     8  width of TCAM key and mask
//   address_size  4  TCAM address width; ENTRIES = 1 << address_size
// PORTS
//   clock         in   1             single clock; all state on rising edge
//   reset         in   1             asynchronous, active-low; clears all state
//   req_valid     in   1             search request present
//   req_ready     out  1             high only in IDLE; accept = req_valid & req_ready
//   req_word      in   word_size     search key
//   req_mask      in   word_size     1 = don't-care bit (TCAM semantics)
//   tcam_word     out  word_size     registered key to TCAM .word
//   tcam_mask     out  word_size     registered mask to TCAM .mask
//   tcam_write    out  1             constant 0; block never writes
//   tcam_matched  in   ENTRIES       TCAM .matched vector, bit i = entry i hits
//   hit_valid     out  1             hit_address valid
//   hit_ready     in   1             consumer accepts hit
//   hit_address   out  address_size  matching entry index
//   hit_last      out  1             with hit_valid: this is the final hit
//   done          out  1             one-cycle pulse at end of each search
//   miss          out  1             with done: search produced zero hits
// BEHAVIOUR
//   Reset (reset == 0): state IDLE. req_ready = 1; tcam_word, tcam_mask and pending = 0;
//     hit_valid, hit_last, done and miss = 0. Asserting reset mid-search aborts the search.
//   FSM states:
//     IDLE    on accept, latch req_word/req_mask into tcam_word/tcam_mask -> SETTLE
//     SETTLE  one cycle for the TCAM match path to settle -> CAPTURE
//     CAPTURE pending <= tcam_matched;
//             if tcam_matched == 0 -> FINISH with miss = 1, else -> EMIT
//     EMIT    hit_address = index of lowest set bit of pending; hit_valid = 1;
//             hit_last = (pending has exactly one bit set);
//             on hit_valid & hit_ready, clear that bit; if hit_last -> FINISH
//     FINISH  done = 1 for one cycle (miss as set in CAPTURE) -> IDLE
//   Latency: accept at cycle 0 -> tcam_* updated at 1 -> capture at 2 -> first hit_valid at 3.
//   While hit_valid = 1 and hit_ready = 0, hit_address and hit_last hold stable.
//   hit_valid never drops without a handshake.
//   Changes on tcam_matched after CAPTURE are ignored; the captured vector is authoritative.
//   All ENTRIES bits set: emits 0..ENTRIES-1 in order; last hit is ENTRIES-1 with hit_last.
//   tcam_word/tcam_mask hold their last value in IDLE. req_* is ignored outside IDLE.
// CONFIGURATION
//   TCAM_HIT_COUNT_EN defined: adds output hit_count [address_size:0].
//     hit_count = popcount(tcam_matched), registered in CAPTURE; holds until the next CAPTURE.
//     Reset value 0.
//   Not defined: the port and popcount logic are absent; all other behaviour is identical.
// STRUCTURE
//   Shared header tcam_defs.vh: FSM state encodings (IDLE, SETTLE, CAPTURE, EMIT, FINISH)
//     and the ENTRIES = 1 << address_size helper, shared with the TCAM and its benches.
//   Sub-module tcam_priority_encoder: combinational lowest-set-bit encoder over ENTRIES
//     bits -> {found, index}. The controller instantiates it once on pending.
// TESTING
//   Instantiate with a real TCAM: write entry 1 = 1001_0111 and entry 4 = 1011_0111.
//   1. reset low for 1 cycle -> req_ready = 1, hit_valid = 0, done = 0, tcam_write = 0.
//   2. Search word 1001_0111, mask 0010_0000, hit_ready = 1
//      -> hit 1 (hit_last = 0), then hit 4 (hit_last = 1), then done = 1, miss = 0.
//   3. Search word 1011_0111, mask 0 -> single hit 4 with hit_last = 1; done = 1.
//   4. Search word 0000_0000, mask 0 -> no hit_valid; done = 1 with miss = 1 at cycle 3.
//   5. Mask all ones (all entries match): hit_ready toggles 0/1 each cycle
//      -> addresses 0..15 in order, each held stable while stalled; 15 has hit_last = 1.
//   6. Drive reset low during EMIT -> next cycle IDLE, hit_valid = 0, req_ready = 1;
//      with TCAM_HIT_COUNT_EN defined, hit_count = 2 after search 2 and 0 after this reset.

Source files
------------

// File: rtl/tcam_search_reader_pkg.sv
// Shared definitions for the TCAM search reader: FSM state encoding and entry-count helper.
// Optional feature macro used by the top level: TCAM_HIT_COUNT_EN.
package tcam_search_reader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CAPTURE = 3'd2,
        EMIT    = 3'd3,
        FINISH  = 3'd4
    } state_t;

    function automatic int tcam_entries(input int address_size);
        return 1 << address_size;
    endfunction

endpackage

// File: rtl/tcam_priority_encoder.sv
// Combinational lowest-set-bit encoder: reports whether any bit is set and the index of the lowest one.
module tcam_priority_encoder
    import tcam_search_reader_pkg::*;
#(
    parameter int address_size = 4,
    localparam int entries = tcam_entries(address_size)
) (
    input  logic [entries-1:0]      bits,
    output logic                    found,
    output logic [address_size-1:0] index
);

    // NOTE: both outputs get a default before the loop so no path leaves them unassigned (no latch).
    always_comb begin
        found = 1'b0;
        index = '0;
        // Scan from the top down so the last assignment wins with the lowest set bit.
        for (int i = entries - 1; i >= 0; i--) begin
            if (bits[i]) begin
                found = 1'b1;
                index = i[address_size-1:0];
            end
        end
    end

endmodule

// File: rtl/tcam_search_reader.sv
// Read-side TCAM controller: launches a masked search, captures the match vector and streams hits lowest first.
// Optional: define TCAM_HIT_COUNT_EN to add the registered hit_count output.
module tcam_search_reader
    import tcam_search_reader_pkg::*;
#(
    parameter int word_size    = 8,
    parameter int address_size = 4,
    localparam int entries     = tcam_entries(address_size)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [word_size-1:0]    req_word,
    input  logic [word_size-1:0]    req_mask,
    output logic [word_size-1:0]    tcam_word,
    output logic [word_size-1:0]    tcam_mask,
    output logic                    tcam_write,
    input  logic [entries-1:0]      tcam_matched,
    output logic                    hit_valid,
    input  logic                    hit_ready,
    output logic [address_size-1:0] hit_address,
    output logic                    hit_last,
    output logic                    done,
    output logic                    miss
`ifdef TCAM_HIT_COUNT_EN
    ,
    output logic [address_size:0]   hit_count
`endif
);

    state_t               state;
    state_t               state_next;
    logic [entries-1:0]   pending;
    logic                 miss_q;
    logic                 hit_found;
    logic                 single_hit;

    assign tcam_write = 1'b0;

    tcam_priority_encoder #(
        .address_size(address_size)
    ) u_priority_encoder (
        .bits (pending),
        .found(hit_found),
        .index(hit_address)
    );

    // Exactly one bit left in pending means the current hit is the final one.
    assign single_hit = hit_found && ((pending & (pending - entries'(1))) == '0);
    assign hit_last   = hit_valid && single_hit;
    assign miss       = done && miss_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tcam_word <= '0;
            tcam_mask <= '0;
            pending   <= '0;
            miss_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (req_valid && req_ready) begin
                tcam_word <= req_word;
                tcam_mask <= req_mask;
            end
            if (state == CAPTURE) begin
                pending <= tcam_matched;
                miss_q  <= (tcam_matched == '0);
            end else if (hit_valid && hit_ready) begin
                pending[hit_address] <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        hit_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = SETTLE;
            end
            SETTLE:  state_next = CAPTURE;
            CAPTURE: state_next = (tcam_matched == '0) ? FINISH : EMIT;
            EMIT: begin
                hit_valid = 1'b1;
                if (hit_ready && single_hit) state_next = FINISH;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef TCAM_HIT_COUNT_EN
    logic [address_size:0] match_count;

    always_comb begin
        match_count = '0;
        for (int i = 0; i < entries; i++) begin
            match_count = match_count + {{address_size{1'b0}}, tcam_matched[i]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count <= '0;
        end else if (state == CAPTURE) begin
            hit_count <= match_count;
        end
    end
`endif

endmodule

// File: tb/tb_tcam_search_reader.sv
// Self-checking bench for tcam_search_reader with a behavioural TCAM and a transaction-level reference model.
module tb_tcam_search_reader;

    localparam int W = 8;
    localparam int A = 4;
    localparam int N = 1 << A;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [W-1:0]   req_word = '0;
    logic [W-1:0]   req_mask = '0;
    logic [W-1:0]   tcam_word;
    logic [W-1:0]   tcam_mask;
    logic           tcam_write;
    logic [N-1:0]   tcam_matched;
    logic           hit_valid;
    logic           hit_ready = 1'b0;
    logic [A-1:0]   hit_address;
    logic           hit_last;
    logic           done;
    logic           miss;
`ifdef TCAM_HIT_COUNT_EN
    logic [A:0]     hit_count;
`endif

    always #5 clock = ~clock;

    tcam_search_reader #(
        .word_size   (W),
        .address_size(A)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_word    (req_word),
        .req_mask    (req_mask),
        .tcam_word   (tcam_word),
        .tcam_mask   (tcam_mask),
        .tcam_write  (tcam_write),
        .tcam_matched(tcam_matched),
        .hit_valid   (hit_valid),
        .hit_ready   (hit_ready),
        .hit_address (hit_address),
        .hit_last    (hit_last),
        .done        (done),
        .miss        (miss)
`ifdef TCAM_HIT_COUNT_EN
        ,
        .hit_count   (hit_count)
`endif
    );

    // Behavioural TCAM: valid entries whose unmasked bits equal the search key hit.
    logic [W-1:0] entry_word [N];
    logic         entry_valid[N];
    logic         override_en = 1'b0;
    logic [N-1:0] override_val = '0;

    always_comb begin
        tcam_matched = '0;
        for (int i = 0; i < N; i++) begin
            if (entry_valid[i] && (((entry_word[i] ^ tcam_word) & ~tcam_mask) == '0))
                tcam_matched[i] = 1'b1;
        end
        if (override_en) tcam_matched = override_val;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one search is accept -> two cycles -> captured list of hits -> done cycle.
    bit       m_busy = 1'b0;
    bit       m_done = 1'b0;
    bit       m_miss = 1'b0;
    int       m_age  = 0;
    int       m_q[$];
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_mask = '0;
    int       m_count = 0;

    int       hs_addr[$];
    bit       hs_last[$];

    always @(negedge clock) begin
        if (!reset) begin
            check("rst_req_ready", req_ready, 1);
            check("rst_hit_valid", hit_valid, 0);
            check("rst_hit_last", hit_last, 0);
            check("rst_done", done, 0);
            check("rst_miss", miss, 0);
            check("rst_tcam_word", tcam_word, 0);
            check("rst_tcam_mask", tcam_mask, 0);
`ifdef TCAM_HIT_COUNT_EN
            check("rst_hit_count", hit_count, 0);
`endif
            m_busy = 1'b0; m_done = 1'b0; m_miss = 1'b0; m_age = 0;
            m_word = '0; m_mask = '0; m_count = 0; m_q.delete();
        end else begin
            bit emit;
            emit = m_busy && !m_done && m_age == 2 && m_q.size() > 0;
            check("req_ready", req_ready, !m_busy);
            check("hit_valid", hit_valid, emit);
            check("done", done, m_done);
            check("miss", miss, m_done && m_miss);
            check("tcam_write", tcam_write, 0);
            check("tcam_word", tcam_word, m_word);
            check("tcam_mask", tcam_mask, m_mask);
            if (emit) begin
                check("hit_address", hit_address, m_q[0]);
                check("hit_last", hit_last, m_q.size() == 1);
            end
`ifdef TCAM_HIT_COUNT_EN
            check("hit_count", hit_count, m_count);
`endif
            if (hit_valid && hit_ready) begin
                hs_addr.push_back(int'(hit_address));
                hs_last.push_back(hit_last);
            end
            // Advance the model to the state after the coming rising edge.
            if (!m_busy) begin
                if (req_valid) begin
                    m_busy = 1'b1; m_age = 0; m_word = req_word; m_mask = req_mask;
                end
            end else if (m_done) begin
                m_busy = 1'b0; m_done = 1'b0;
            end else if (m_age < 2) begin
                m_age++;
                if (m_age == 2) begin
                    m_q.delete();
                    for (int i = 0; i < N; i++) if (tcam_matched[i]) m_q.push_back(i);
                    m_count = m_q.size();
                    m_miss  = (m_q.size() == 0);
                    m_done  = m_miss;
                end
            end else if (hit_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end
    end

    // mode: 0 = always ready, 1 = toggle starting at 0, 2 = random. junk scrambles req_* and overrides while busy.
    task automatic run_search(input logic [W-1:0] w, input logic [W-1:0] m, input int mode, input bit junk,
                              output int first_hit, output int done_cyc, output bit miss_seen);
        int cyc;
        hs_addr.delete();
        hs_last.delete();
        first_hit = -1;
        done_cyc  = -1;
        miss_seen = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b1; req_word = w; req_mask = m;
        @(posedge clock); #1;
        req_valid = 1'b0;
        cyc = 1;
        for (int k = 0; k < 300; k++) begin
            case (mode)
                0:       hit_ready = 1'b1;
                1:       hit_ready = (k % 2) == 1;
                default: hit_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clock);
            if (hit_valid && first_hit < 0) first_hit = cyc;
            if (done) begin
                done_cyc  = cyc;
                miss_seen = miss;
                break;
            end
            @(posedge clock); #1;
            cyc++;
            if (junk) begin
                req_valid = 1'($urandom_range(0, 1));
                req_word  = W'($urandom);
                req_mask  = W'($urandom);
            end
            if (override_en) override_val = N'($urandom);
        end
        if (done_cyc < 0) begin
            checks++; errors++;
            $display("FAIL search_timeout: no done within 300 cycles for word %0h", w);
        end
    endtask

    task automatic program_two_entries();
        for (int i = 0; i < N; i++) begin
            entry_valid[i] = 1'b0;
            entry_word[i]  = '0;
        end
        entry_word[1] = 8'b1001_0111; entry_valid[1] = 1'b1;
        entry_word[4] = 8'b1011_0111; entry_valid[4] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  fh, dc, k;
        bit  ms;
        program_two_entries();

        // 1. Reset
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("t1_req_ready", req_ready, 1);
        check("t1_hit_valid", hit_valid, 0);
        check("t1_done", done, 0);
        check("t1_tcam_write", tcam_write, 0);

        // 2. Two hits, masked bit 5
        run_search(8'b1001_0111, 8'b0010_0000, 0, 1'b0, fh, dc, ms);
        check("t2_first_hit_cycle", fh, 3);
        check("t2_hit_count", hs_addr.size(), 2);
        if (hs_addr.size() == 2) begin
            check("t2_addr0", hs_addr[0], 1);
            check("t2_last0", hs_last[0], 0);
            check("t2_addr1", hs_addr[1], 4);
            check("t2_last1", hs_last[1], 1);
        end
        check("t2_miss", ms, 0);

        // 3. Single hit
        run_search(8'b1011_0111, 8'b0000_0000, 0, 1'b0, fh, dc, ms);
        check("t3_hit_count", hs_addr.size(), 1);
        if (hs_addr.size() == 1) begin
            check("t3_addr", hs_addr[0], 4);
            check("t3_last", hs_last[0], 1);
        end
        check("t3_miss", ms, 0);

        // 4. Miss: done with miss at cycle 3, no hit_valid
        run_search(8'h00, 8'h00, 0, 1'b0, fh, dc, ms);
        check("t4_no_hit", fh, -1);
        check("t4_done_cycle", dc, 3);
        check("t4_miss", ms, 1);

        // 5. All entries match, consumer stalls every other cycle
        for (int i = 0; i < N; i++) begin
            entry_valid[i] = 1'b1;
            entry_word[i]  = W'($urandom);
        end
        run_search(8'h5a, 8'hff, 1, 1'b0, fh, dc, ms);
        check("t5_hit_count", hs_addr.size(), N);
        for (int i = 0; i < hs_addr.size(); i++) begin
            check("t5_addr", hs_addr[i], i);
            check("t5_last", hs_last[i], i == N - 1);
        end

        // 6. Reset in the middle of EMIT
        program_two_entries();
        @(posedge clock); #1;
        req_valid = 1'b1; req_word = 8'b1001_0111; req_mask = 8'b0010_0000; hit_ready = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        k = 0;
        while (k < 10) begin
            @(negedge clock);
            if (hit_valid) break;
            @(posedge clock); #1;
            k++;
        end
        check("t6_reached_emit", hit_valid, 1);
        check("t6_stalled_addr", hit_address, 1);
`ifdef TCAM_HIT_COUNT_EN
        check("t6_hit_count_before", hit_count, 2);
`endif
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("t6_hit_valid", hit_valid, 0);
        check("t6_req_ready", req_ready, 1);
`ifdef TCAM_HIT_COUNT_EN
        check("t6_hit_count_after", hit_count, 0);
`endif
        @(posedge clock); #1;
        reset = 1'b1;
        run_search(8'b1011_0111, 8'b0000_0000, 0, 1'b0, fh, dc, ms);
        check("t6_recover_hits", hs_addr.size(), 1);

        // Randomised searches with junk on req_* and a changing match vector after capture
        for (int s = 0; s < 150; s++) begin
            for (int i = 0; i < N; i++) begin
                entry_valid[i] = 1'($urandom_range(0, 1));
                entry_word[i]  = W'($urandom_range(0, 15));
            end
            override_en  = ($urandom_range(0, 3) == 0);
            override_val = N'($urandom);
            run_search(W'($urandom_range(0, 15)), W'($urandom & $urandom), 2, 1'b1, fh, dc, ms);
        end

        @(posedge clock); #1;
        req_valid = 1'b0; override_en = 1'b0;
        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
